// File: rtl/next_level_memory_if.sv
// Request/response bus between a cache's next-level port and its word-addressed backing store.
// The cache drives the request side (master); the backing store answers (slave).
interface next_level_memory_if #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32
);

  logic                    request;
  logic                    write;
  logic [ADDRESSWIDTH-1:0] address;
  logic [DATAWIDTH-1:0]    wdata;
  logic                    ack;
  logic [DATAWIDTH-1:0]    rdata;
  logic                    error;
  logic                    busy;

  modport master (
    output request, write, address, wdata,
    input  ack, rdata, error, busy
  );

  modport slave (
    input  request, write, address, wdata,
    output ack, rdata, error, busy
  );

endinterface

// File: rtl/next_level_memory.sv
// Backing-store responder for one cache: a single access in flight, fixed access latency,
// registered single-cycle acknowledge, and saturating counters of completed in-range accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | ready; a sampled request is latched and the wait counter loaded
// WAIT    | counting down the access latency
// RESPOND | ack cycle; the access was committed on the edge entering it
module next_level_memory #(
  parameter int                   DATAWIDTH    = 32,
  parameter int                   ADDRESSWIDTH = 32,
  parameter int                   DEPTH        = 1024,
  parameter int                   LATENCY      = 4,
  parameter logic [DATAWIDTH-1:0] FILL         = DATAWIDTH'(32'h0BEEFA55)
) (
  input  logic                clock,
  input  logic                reset,
  next_level_memory_if.slave  bus,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count
);

  localparam int IDXW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [7:0]              cnt_q;
  logic [7:0]              cnt_d;
  logic                    run_q;
  logic                    accept;
  logic                    commit;

  logic                    write_q;
  logic [ADDRESSWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0]    wdata_q;

  logic                    acc_write;
  logic [ADDRESSWIDTH-1:0] acc_addr;
  logic [DATAWIDTH-1:0]    acc_wdata;
  logic [ADDRESSWIDTH-1:0] word_addr;
  logic [IDXW-1:0]         acc_idx;
  logic                    acc_oor;

  logic                    ack_q;
  logic                    error_q;
  logic                    busy_q;
  logic [DATAWIDTH-1:0]    rdata_q;
  logic [31:0]             read_count_q;
  logic [31:0]             write_count_q;

  // Storage is not reset: contents survive reset and start out as FILL.
  logic [DATAWIDTH-1:0]    mem [DEPTH] = '{default: FILL};

  // One-stage release synchroniser: the first request is taken on the second edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && bus.request) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESPOND;
          commit  = 1'b1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= bus.write;
      addr_q  <= bus.address;
      wdata_q <= bus.wdata;
    end
  end

  // With LATENCY=1 the commit edge is the sample edge, so the live bus is used directly.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_write = bus.write;
      acc_addr  = bus.address;
      acc_wdata = bus.wdata;
    end
  end

  assign word_addr = acc_addr >> 2;
  assign acc_idx   = word_addr[IDXW-1:0];
  assign acc_oor   = |(word_addr >> IDXW);

  always_ff @(posedge clock) begin
    if (commit && acc_write && !acc_oor) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= commit;
      error_q <= commit & acc_oor;
      busy_q  <= (state_d != IDLE);
      rdata_q <= '0;
      if (commit && !acc_write) begin
        rdata_q <= acc_oor ? FILL : mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_count_q  <= 32'd0;
      write_count_q <= 32'd0;
    end else if (commit && !acc_oor) begin
      if (acc_write) begin
        if (write_count_q != 32'hFFFF_FFFF) begin
          write_count_q <= write_count_q + 32'd1;
        end
      end else begin
        if (read_count_q != 32'hFFFF_FFFF) begin
          read_count_q <= read_count_q + 32'd1;
        end
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.error   = error_q;
  assign bus.busy    = busy_q;
  assign bus.rdata   = rdata_q;
  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule
